// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Used by mult_datapath and seq_mult_n.
package mult_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] x,
    input logic             neg
  );
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator, final sign fix-up.
// MULT_EARLY_TERM_EN lets RUN end once no multiplier bits remain.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               run_last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;

  assign neg_a = signed_mode & a[WIDTH-1];
  assign neg_b = signed_mode & b[WIDTH-1];
  assign mag_a = WIDTH'(abs_w(MAX_W'(a), neg_a));
  assign mag_b = WIDTH'(abs_w(MAX_W'(b), neg_b));

`ifdef MULT_EARLY_TERM_EN
  assign run_last = (cnt == CNT_W'(WIDTH-1)) ||
                    (mplier[WIDTH-1:1] == '0);
`else
  assign run_last = (cnt == CNT_W'(WIDTH-1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign_r  <= 1'b0;
      product <= '0;
    end else if (load) begin
      mcand  <= PW'(mag_a);
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= '0;
      sign_r <= neg_a ^ neg_b;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (finish) begin
      // acc already holds the last partial sum here
      product <= sign_r ? -acc : acc;
    end
  end

endmodule

// File: rtl/seq_mult_n.sv
// Sequential WIDTH x WIDTH multiplier with start/busy/done handshake.
// Define MULT_EARLY_TERM_EN to shorten RUN for small multipliers.
module seq_mult_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state;
  logic   load;
  logic   step;
  logic   finish;
  logic   run_last;

  assign load   = (state == IDLE) & start;
  assign step   = (state == RUN);
  assign finish = (state == FIN);

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .run_last   (run_last),
    .product    (product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (run_last) begin
            state <= FIN;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_n.sv
// Bench for seq_mult_n at WIDTH=4 and WIDTH=8 against an arithmetic model.
// Honours MULT_EARLY_TERM_EN when predicting RUN length.
module tb_seq_mult_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_mult_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mult_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int w, input int av,
                                        input int bv, input bit sm);
    longint x, y, p, m;
    x = av;
    y = bv;
    if (sm && x >= (longint'(1) << (w-1))) x -= longint'(1) << w;
    if (sm && y >= (longint'(1) << (w-1))) y -= longint'(1) << w;
    p = x * y;
    m = (longint'(1) << (2*w)) - 1;
    return 32'(p & m);
  endfunction

  function automatic int run_len(input int w, input int bv, input bit sm);
    int mag, n;
    mag = (sm && bv >= (1 << (w-1))) ? (1 << w) - bv : bv;
    n = 1;
    for (int i = 0; i < w; i++)
      if (((mag >> i) & 1) != 0) n = i + 1;
`ifdef MULT_EARLY_TERM_EN
    return n;
`else
    return (n > 0) ? w : w;
`endif
  endfunction

  task automatic drive(input int w, input logic s, input int av,
                       input int bv, input logic sm);
    if (w == 4) begin
      start4 = s; a4 = 4'(av); b4 = 4'(bv); sm4 = sm;
    end else begin
      start8 = s; a8 = 8'(av); b8 = 8'(bv); sm8 = sm;
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    return (w == 4) ? 32'(prod4) : 32'(prod8);
  endfunction

  // Starts one operation, follows it to done and checks timing and result.
  // With sync=0 the start is driven in the current (done) cycle.
  task automatic op(input int w, input int av, input int bv,
                    input bit sm, input bit sync, input string tag);
    logic [31:0] exp;
    int rl, edges, busy_n;
    exp = model(w, av, bv, sm);
    rl = run_len(w, bv, sm);
    if (sync) @(negedge clk);
    drive(w, 1'b1, av, bv, sm);
    @(posedge clk); #1;
    drive(w, 1'b0, int'($urandom), int'($urandom), 1'($urandom));
    edges = 0;
    busy_n = 0;
    while (get_done(w) !== 1'b1 && edges < 40) begin
      if (get_busy(w) === 1'b1) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, " done"}, 32'(get_done(w)), 32'd1);
    chk({tag, " latency"}, 32'(edges), 32'(rl + 1));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(rl));
    chk({tag, " product"}, get_prod(w), exp);
  endtask

  initial begin
    bit seen;
    int lat;

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy4", 32'(busy4), 32'd0);
    chk("rst done4", 32'(done4), 32'd0);
    chk("rst prod4", 32'(prod4), 32'd0);
    chk("rst prod8", 32'(prod8), 32'd0);
    rst_n = 1'b1;

    op(4, 15, 15, 1'b0, 1'b1, "u15x15");
    chk("u15x15 value", 32'(prod4), 32'hE1);
    @(posedge clk); #1;
    chk("done pulse", 32'(done4), 32'd0);
    chk("prod held", 32'(prod4), 32'hE1);

    op(4, 4'hD, 5, 1'b1, 1'b1, "s-3x5");
    chk("s-3x5 value", 32'(prod4), 32'hF1);
    op(4, 8, 8, 1'b1, 1'b1, "s-8x-8");
    chk("s-8x-8 value", 32'(prod4), 32'h40);
    op(4, 8, 7, 1'b1, 1'b1, "s-8x7");
    chk("s-8x7 value", 32'(prod4), 32'hC8);
    op(4, 9, 0, 1'b0, 1'b1, "u9x0");
    op(4, 9, 2, 1'b0, 1'b1, "u9x2");
    chk("u9x2 value", 32'(prod4), 32'd18);

    // start held through RUN with other operands must not disturb 3*5
    @(negedge clk);
    drive(4, 1'b1, 3, 5, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b1, 7, 7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    drive(4, 1'b0, 7, 7, 1'b1);
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold done", 32'(done4), 32'd1);
    chk("hold product", 32'(prod4), 32'd15);
    op(4, 2, 6, 1'b0, 1'b0, "b2b");
    chk("b2b value", 32'(prod4), 32'd12);

    // reset in the middle of RUN
    @(negedge clk);
    drive(4, 1'b1, 5, 3, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", 32'(busy4), 32'd0);
    chk("midrst done", 32'(done4), 32'd0);
    chk("midrst prod", 32'(prod4), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4 !== 1'b0) seen = 1'b1;
    end
    chk("midrst no done", 32'(seen), 32'd0);
    op(4, 5, 3, 1'b0, 1'b1, "post_rst");

    op(8, 255, 255, 1'b0, 1'b1, "u255x255");
    chk("u255 value", 32'(prod8), 32'hFE01);
    op(8, 128, 128, 1'b1, 1'b1, "s-128x-128");
    chk("s-128 value", 32'(prod8), 32'h4000);

    for (int i = 0; i < 20; i++)
      op(4, int'($urandom_range(15)), int'($urandom_range(15)),
         1'($urandom), 1'b1, "rnd4");
    for (int i = 0; i < 30; i++)
      op(8, int'($urandom_range(255)), int'($urandom_range(255)),
         1'($urandom), 1'b1, "rnd8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
